// File: rtl/output_deskew_array.sv
`default_nettype none
// ============================================================================
// Module   : output_deskew_array
// Purpose  : Re-aligns the diagonally skewed result stream leaving the
//            systolic array edge into whole vectors and buffers them in a
//            small FIFO with a valid/ready output.
//            Lane i carries HIGHT-i {valid,data} stages, so lane i entering
//            one advance after lane i-1 lines up at the delay-line head.
//            A full FIFO raises stall, which freezes the array and this block.
// Options  : DESKEW_SKEW_CHECK_EN - when defined, the head vector must be all
//            valid or all invalid; mixed heads are dropped and set a sticky
//            skew_err. When undefined, lane 0 alone decides the push and
//            skew_err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module output_deskew_array #(
  parameter int HIGHT      = 32,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [DATA_WIDTH*HIGHT-1:0] in,
  input  logic [HIGHT-1:0]            in_valid,
  output logic                        stall,
  output logic [DATA_WIDTH*HIGHT-1:0] out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [15:0]                 word_count,
  output logic                        skew_err
);

  localparam int c_VW = DATA_WIDTH * HIGHT;
  localparam int c_PW = $clog2(FIFO_DEPTH);
  localparam int c_CW = c_PW + 1;
`ifdef DESKEW_SKEW_CHECK_EN
  localparam bit c_SKEW_CHECK = 1'b1;
`else
  localparam bit c_SKEW_CHECK = 1'b0;
`endif

  logic              w_advance;
  logic              w_push;
  logic              w_pop;
  logic              w_mixed;
  logic [c_VW-1:0]   w_head_data;
  logic [HIGHT-1:0]  w_head_valid;

  logic [c_PW-1:0]   r_wr_ptr;
  logic [c_PW-1:0]   r_rd_ptr;
  logic [c_CW-1:0]   r_count;
  logic [c_VW-1:0]   r_mem [FIFO_DEPTH];
  logic [15:0]       r_word_count;
  logic              r_skew_err;

  // Stall depends on registered occupancy only, so it never loops back
  // combinationally through the upstream enable.
  assign stall     = (r_count == c_CW'(FIFO_DEPTH));
  assign w_advance = enable & ~stall;
  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid & out_ready;
  assign out       = r_mem[r_rd_ptr];

  genvar gi;
  generate
    for (gi = 0; gi < HIGHT; gi++) begin : g_lane
      localparam int c_LEN = HIGHT - gi;
      logic [DATA_WIDTH-1:0] r_d [c_LEN];

      // Data delay line for this lane; every lane, including lane 0, is gated.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < c_LEN; k++) r_d[k] <= '0;
        end else if (w_advance) begin
          r_d[0] <= in[DATA_WIDTH*(gi+1)-1 -: DATA_WIDTH];
          for (int k = 1; k < c_LEN; k++) r_d[k] <= r_d[k-1];
        end
      end

      assign w_head_data[DATA_WIDTH*(gi+1)-1 -: DATA_WIDTH] = r_d[c_LEN-1];

      if (c_SKEW_CHECK || (gi == 0)) begin : g_valid
        logic [c_LEN-1:0] r_v;

        // Valid delay line, shifted in lock-step with the data line.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_v <= '0;
          end else if (w_advance) begin
            r_v[0] <= in_valid[gi];
            for (int k = 1; k < c_LEN; k++) r_v[k] <= r_v[k-1];
          end
        end

        assign w_head_valid[gi] = r_v[c_LEN-1];
      end else begin : g_no_valid
        // Only lane 0's valid matters without the skew check.
        assign w_head_valid[gi] = 1'b0;
      end
    end
  endgenerate

`ifdef DESKEW_SKEW_CHECK_EN
  assign w_push  = w_advance & (&w_head_valid);
  assign w_mixed = w_advance & (|w_head_valid) & ~(&w_head_valid);
`else
  logic w_unused_valid;
  assign w_push         = w_advance & w_head_valid[0];
  assign w_mixed        = 1'b0;
  assign w_unused_valid = &{1'b0, in_valid[HIGHT-1:1], w_head_valid[HIGHT-1:1]};
`endif

  // FIFO storage; contents need no reset because out_valid masks them.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_head_data;
  end

  // FIFO pointers and occupancy; power-of-two depth lets pointers wrap freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Popped-vector counter and sticky misalignment flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_count <= '0;
      r_skew_err   <= 1'b0;
    end else begin
      if (w_pop)   r_word_count <= r_word_count + 16'd1;
      if (w_mixed) r_skew_err   <= 1'b1;
    end
  end

  assign word_count = r_word_count;
  assign skew_err   = r_skew_err;

endmodule
`default_nettype wire

// File: tb/tb_output_deskew_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_output_deskew_array
// Purpose  : Self-checking bench for output_deskew_array (HIGHT=4, depth 4).
//            The reference keeps a per-lane history of everything presented
//            on each advance step; lane i's head on step s is the element it
//            was given on step s-(HIGHT-i). Aligned vectors go into a queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_output_deskew_array;

  localparam int H     = 4;
  localparam int DW    = 16;
  localparam int FD    = 4;
  localparam int VW    = H * DW;
  localparam int NHIST = 4096;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b1;
  logic          enable    = 1'b0;
  logic          out_ready = 1'b0;
  logic [VW-1:0] in_data   = '0;
  logic [H-1:0]  in_valid  = '0;
  logic          stall;
  logic          out_valid;
  logic          skew_err;
  logic [VW-1:0] out_data;
  logic [15:0]   word_count;

  output_deskew_array #(.HIGHT(H), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in(in_data), .in_valid(in_valid),
    .stall(stall), .out(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .word_count(word_count), .skew_err(skew_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model state
  logic [VW-1:0] mq[$];
  int            m_step;
  bit            m_err;
  logic [15:0]   m_wc;
  bit            hv [H][NHIST];
  logic [DW-1:0] hd [H][NHIST];

  // Skewed-injection driver state
  logic [DW-1:0] vecs [8][H];
  int            nvec, gap, late_vec, late_lane, t_inj;
  bit            inj_on;

  wire [18:0] got_status = {out_valid, stall, skew_err, word_count};

  function automatic logic [18:0] exp_status();
    return {mq.size() != 0, mq.size() == FD, m_err, m_wc};
  endfunction

  function automatic logic [VW-1:0] pack(int k);
    logic [VW-1:0] r;
    for (int i = 0; i < H; i++) r[DW*i +: DW] = vecs[k][i];
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_step = 0; m_err = 1'b0; m_wc = '0; t_inj = 0; inj_on = 1'b0;
  endtask

  task automatic setup_vecs(int n, int g, int lv, int ll);
    nvec = n; gap = g; late_vec = lv; late_lane = ll; t_inj = 0;
    for (int k = 0; k < n; k++)
      for (int i = 0; i < H; i++) vecs[k][i] = DW'($urandom);
  endtask

  // Drive one cycle of skewed stimulus, advance the model, and step the clock.
  task automatic cycle();
    bit            adv, pop, v;
    int            idx;
    logic [H-1:0]  vm;
    logic [VW-1:0] hvec;
    for (int i = 0; i < H; i++) begin
      v = 1'b0;
      in_data[DW*i +: DW] = DW'($urandom);
      if (inj_on)
        for (int k = 0; k < nvec; k++)
          if (t_inj == k*gap + i + ((k == late_vec && i == late_lane) ? 1 : 0)) begin
            v = 1'b1;
            in_data[DW*i +: DW] = vecs[k][i];
          end
      in_valid[i] = v;
    end
    adv  = enable && (mq.size() != FD);
    pop  = (mq.size() != 0) && out_ready;
    vm   = '0;
    hvec = '0;
    if (adv) begin
      for (int i = 0; i < H; i++) begin
        idx = m_step - (H - i);
        if (idx >= 0) begin
          vm[i] = hv[i][idx];
          hvec[DW*i +: DW] = hd[i][idx];
        end
      end
      for (int i = 0; i < H; i++) begin
        hv[i][m_step] = in_valid[i];
        hd[i][m_step] = in_data[DW*i +: DW];
      end
      m_step++;
    end
    if (pop) begin
      void'(mq.pop_front());
      m_wc++;
    end
    if (adv) begin
`ifdef DESKEW_SKEW_CHECK_EN
      if (&vm) mq.push_back(hvec);
      else if (|vm) m_err = 1'b1;
`else
      if (vm[0]) mq.push_back(hvec);
`endif
    end
    if (inj_on && adv) t_inj++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; out_ready = 1'b0; inj_on = 1'b0; in_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    cyc = 0;
  endtask

  task automatic test_reset();
    #2;
    rst_n = 1'b0; enable = 1'b0; out_ready = 1'b0;
    #1;
    checks++;
    if (got_status !== 19'd0) begin
      errors++; $display("FAIL reset_state got=%h exp=%h", got_status, 19'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    setup_vecs(0, 1, -1, -1);
    @(posedge clk);
    #1;
    cyc = 0; enable = 1'b1; out_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      cycle();
      checks++;
      if (got_status !== exp_status()) begin
        errors++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, got_status, exp_status());
      end
    end
  endtask

  task automatic test_single();
    int            first = -1, nval = 0;
    logic [VW-1:0] got = '0;
    do_reset();
    setup_vecs(1, 1, -1, -1);
    for (int i = 0; i < H; i++) vecs[0][i] = DW'(16'h10 + i);
    enable = 1'b1; out_ready = 1'b1;
    for (int n = 0; n < 14; n++) begin
      inj_on = (cyc >= 2);
      if (out_valid) begin
        nval++;
        if (first < 0) first = cyc;
        got = out_data;
      end
      cycle();
      checks++;
      if (got_status !== exp_status()) begin
        errors++; $display("FAIL single_status cyc=%0d got=%h exp=%h", cyc, got_status, exp_status());
      end
      if (mq.size() != 0) begin
        checks++;
        if (out_data !== mq[0]) begin
          errors++; $display("FAIL single_head cyc=%0d got=%h exp=%h", cyc, out_data, mq[0]);
        end
      end
    end
    checks++;
    if (first != 7) begin errors++; $display("FAIL single_latency got=%0d exp=7", first); end
    checks++;
    if (nval != 1) begin errors++; $display("FAIL single_valid_cycles got=%0d exp=1", nval); end
    checks++;
    if (got !== 64'h0013_0012_0011_0010) begin
      errors++; $display("FAIL single_data got=%h exp=%h", got, 64'h0013_0012_0011_0010);
    end
    checks++;
    if (word_count !== 16'd1) begin errors++; $display("FAIL single_wc got=%0d exp=1", word_count); end
  endtask

  task automatic test_backpressure();
    logic [VW-1:0] popped[$];
    int            first_stall = -1;
    do_reset();
    setup_vecs(6, 1, -1, -1);
    enable = 1'b1; out_ready = 1'b0; inj_on = 1'b1;
    for (int n = 0; n < 20; n++) begin
      cycle();
      if (stall && first_stall < 0) first_stall = cyc;
      checks++;
      if (got_status !== exp_status()) begin
        errors++; $display("FAIL bp_hold_status cyc=%0d got=%h exp=%h", cyc, got_status, exp_status());
      end
    end
    checks++;
    if (first_stall != 4 + H) begin
      errors++; $display("FAIL bp_stall_cycle got=%0d exp=%0d", first_stall, 4 + H);
    end
    out_ready = 1'b1;
    for (int n = 0; n < 30; n++) begin
      if (out_valid) popped.push_back(out_data);
      cycle();
      checks++;
      if (got_status !== exp_status()) begin
        errors++; $display("FAIL bp_drain_status cyc=%0d got=%h exp=%h", cyc, got_status, exp_status());
      end
      if (mq.size() != 0) begin
        checks++;
        if (out_data !== mq[0]) begin
          errors++; $display("FAIL bp_head cyc=%0d got=%h exp=%h", cyc, out_data, mq[0]);
        end
      end
    end
    checks++;
    if (popped.size() != 6) begin errors++; $display("FAIL bp_count got=%0d exp=6", popped.size()); end
    for (int k = 0; k < 6 && k < popped.size(); k++) begin
      checks++;
      if (popped[k] !== pack(k)) begin
        errors++; $display("FAIL bp_order k=%0d got=%h exp=%h", k, popped[k], pack(k));
      end
    end
    checks++;
    if (word_count !== 16'd6) begin errors++; $display("FAIL bp_wc got=%0d exp=6", word_count); end
  endtask

  task automatic test_enable_toggle();
    logic [VW-1:0] popped[$];
    int            first = -1, nstall = 0;
    do_reset();
    setup_vecs(3, 1, -1, -1);
    out_ready = 1'b1;
    for (int n = 0; n < 30; n++) begin
      enable = (cyc % 2 == 0);
      inj_on = (cyc >= 2);
      if (out_valid) begin
        popped.push_back(out_data);
        if (first < 0) first = cyc;
      end
      if (stall) nstall++;
      cycle();
      checks++;
      if (got_status !== exp_status()) begin
        errors++; $display("FAIL toggle_status cyc=%0d got=%h exp=%h", cyc, got_status, exp_status());
      end
    end
    checks++;
    if (first != 2 + 2*H + 1) begin
      errors++; $display("FAIL toggle_latency got=%0d exp=%0d", first, 2 + 2*H + 1);
    end
    checks++;
    if (popped.size() != 3) begin errors++; $display("FAIL toggle_count got=%0d exp=3", popped.size()); end
    for (int k = 0; k < 3 && k < popped.size(); k++) begin
      checks++;
      if (popped[k] !== pack(k)) begin
        errors++; $display("FAIL toggle_data k=%0d got=%h exp=%h", k, popped[k], pack(k));
      end
    end
    checks++;
    if (skew_err !== 1'b0 || nstall != 0) begin
      errors++; $display("FAIL toggle_err_stall got err=%b stalls=%0d exp err=0 stalls=0", skew_err, nstall);
    end
  endtask

  task automatic test_skew();
    logic [VW-1:0] popped[$];
    int            first_err = -1;
    do_reset();
    setup_vecs(3, 2, 0, 2);
    enable = 1'b1; out_ready = 1'b1; inj_on = 1'b1;
    for (int n = 0; n < 25; n++) begin
      if (out_valid) popped.push_back(out_data);
      cycle();
      if (skew_err && first_err < 0) first_err = cyc;
      checks++;
      if (got_status !== exp_status()) begin
        errors++; $display("FAIL skew_status cyc=%0d got=%h exp=%h", cyc, got_status, exp_status());
      end
    end
`ifdef DESKEW_SKEW_CHECK_EN
    checks++;
    if (popped.size() != 2) begin errors++; $display("FAIL skew_count got=%0d exp=2", popped.size()); end
    for (int k = 0; k < 2 && k < popped.size(); k++) begin
      checks++;
      if (popped[k] !== pack(k + 1)) begin
        errors++; $display("FAIL skew_data k=%0d got=%h exp=%h", k, popped[k], pack(k + 1));
      end
    end
    checks++;
    if (skew_err !== 1'b1 || first_err != H + 1) begin
      errors++; $display("FAIL skew_flag got=%b at %0d exp=1 at %0d", skew_err, first_err, H + 1);
    end
`else
    checks++;
    if (popped.size() != 3) begin errors++; $display("FAIL skew_count got=%0d exp=3", popped.size()); end
    if (popped.size() == 3) begin
      checks++;
      if ({popped[0][4*DW-1:3*DW], popped[0][2*DW-1:0]} !== {vecs[0][3], vecs[0][1], vecs[0][0]}) begin
        errors++; $display("FAIL skew_data0 got=%h", popped[0]);
      end
      checks++;
      if (popped[1] !== pack(1) || popped[2] !== pack(2)) begin
        errors++; $display("FAIL skew_data12 got=%h %h exp=%h %h", popped[1], popped[2], pack(1), pack(2));
      end
    end
    checks++;
    if (skew_err !== 1'b0) begin errors++; $display("FAIL skew_flag got=%b exp=0", skew_err); end
`endif
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    setup_vecs(4, 1, -1, -1);
    enable = 1'b1; out_ready = 1'b0; inj_on = 1'b1;
    for (int n = 0; n < 20 && mq.size() != 2; n++) begin
      cycle();
      checks++;
      if (got_status !== exp_status()) begin
        errors++; $display("FAIL rmid_fill_status cyc=%0d got=%h exp=%h", cyc, got_status, exp_status());
      end
    end
    checks++;
    if (out_valid !== 1'b1 || mq.size() != 2) begin
      errors++; $display("FAIL rmid_fill got ov=%b entries=%0d exp ov=1 entries=2", out_valid, mq.size());
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (got_status !== 19'd0) begin
      errors++; $display("FAIL rmid_async got=%h exp=%h", got_status, 19'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0; enable = 1'b1; out_ready = 1'b1;
    for (int n = 0; n < 15; n++) begin
      if (out_valid) stale++;
      cycle();
      checks++;
      if (got_status !== exp_status()) begin
        errors++; $display("FAIL rmid_after_status cyc=%0d got=%h exp=%h", cyc, got_status, exp_status());
      end
    end
    checks++;
    if (stale != 0) begin errors++; $display("FAIL rmid_stale got=%0d exp=0", stale); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_enable_toggle();
    test_skew();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/output_deskew_array.md
# output_deskew_array

Inverse of the input-side triangle skew: it re-aligns the diagonally skewed result stream leaving the systolic array edge into whole vectors and buffers them in a small FIFO with a valid/ready output. Lane i has `HIGHT-i` register stages, so an element injected on lane i one cycle after lane i-1 lines up at the delay-line output. It sits between the array's output edge and the result writeback path. It also drives a stall back to the array so that a full buffer freezes the array and this block together.

## Interface
- `HIGHT`, 32: number of lanes (array edge width); ≥ 2.
- `DATA_WIDTH`, 16: bits per lane element.
- `FIFO_DEPTH`, 4: aligned-vector buffer entries; power of two, ≥ 2.

- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `enable` input 1: upstream array advance; same gating meaning as the input shifters.
- `in` input `DATA_WIDTH*HIGHT`: skewed lane data; lane i at `[DATA_WIDTH*(i+1)-1 -: DATA_WIDTH]`.
- `in_valid` input `HIGHT`: per-lane element valid.
- `stall` output 1: FIFO full; upstream must treat its own enable as `enable & ~stall`.
- `out` output `DATA_WIDTH*HIGHT`: aligned vector at FIFO head.
- `out_valid` output 1: FIFO non-empty.
- `out_ready` input 1: consumer accepts `out` this cycle.
- `word_count` output 16: vectors popped since reset, wraps at 2^16.
- `skew_err` output 1: sticky misalignment flag.

## Operation
- Internal `advance = enable & ~stall`, with `stall = (count == FIFO_DEPTH)`, a function of registered state only.
- Delay lines:
  - Lane i is a chain of `HIGHT-i` stages carrying `{valid, data}`.
  - All stages shift only when `advance` is high and hold otherwise. This applies to lane 0 too; no lane is ungated.
- Head detection on an `advance` cycle, at the delay-line outputs:
  - All lane valids 1: push the aligned vector into the FIFO.
  - All lane valids 0: no action.
  - Mixed: drop the vector and set `skew_err`. It stays set until reset.
- FIFO:
  - Circular buffer with wrapping read/write pointers and a `count` of 0..`FIFO_DEPTH`.
  - Pop when `out_valid & out_ready`.
  - Push and pop in the same cycle leaves `count` unchanged.
  - Push never occurs when full, because `advance` is 0 then. A pop on a full cycle does not release `stall` until the next cycle (conservative).
- `out` shows the head entry. Its contents are don't-care while `out_valid`=0.
- `word_count` increments on every pop.
- Reset (async, including mid-operation):
  - All delay stages, data and valid, go to 0.
  - Pointers and `count` go to 0.
  - `skew_err`=0, `word_count`=0, `out_valid`=0, `stall`=0.
  - In-flight and buffered data are discarded.

## Timing
- Lane 0 element presented in advance-cycle c, lane i element in c+i: the aligned vector is visible at the delay-line output in c+`HIGHT` and pushed at the end of that cycle.
- `out_valid` rises in cycle c+`HIGHT`+1 (latency `HIGHT`+1 with no stalls and an empty FIFO).
- Cycles with `advance`=0 add one cycle each to the latency and preserve alignment.
- Back-to-back vectors (one per cycle) with `out_ready`=1 sustain full throughput with `stall` never asserted.
- `stall` asserts in the cycle after the push that fills the FIFO. It deasserts in the cycle after the first pop from full.
- `skew_err` rises in the cycle after the offending head cycle.

## Configuration
- `DESKEW_SKEW_CHECK_EN` defined:
  - Full all-or-none valid check as above.
  - `skew_err` is live.
- `DESKEW_SKEW_CHECK_EN` undefined:
  - Push is decided by lane 0's output valid alone.
  - Other lanes' valids are ignored.
  - `skew_err` is tied to 0.
  - The valid chains for lanes 1..`HIGHT-1` may be removed.

## Test plan
- `HIGHT`=4, `FIFO_DEPTH`=4, `out_ready`=1, `enable`=1: inject lane i = 0x10+i at cycle 2+i -> `out_valid` high in cycle 7 only, `out`={0x13,0x12,0x11,0x10}, `word_count`=1.
- 6 consecutive skewed vectors, `out_ready`=0 -> 4 vectors buffered, `stall`=1 from the cycle after the 4th push. Release `out_ready` -> vectors 1..6 popped in order with no loss or duplication, `word_count`=6.
- `enable` toggled 0/1 every cycle during injection (data held while low) -> same aligned values, latency doubled, `skew_err`=0.
- Lane 2 injected one cycle late -> vector dropped, `skew_err`=1 and sticky, later correct vectors still delivered (with macro). Without the macro -> vector pushed, `skew_err`=0.
- Assert `rst_n`=0 mid-stream with 2 entries buffered and data in the delay lines -> immediately `out_valid`=0, `stall`=0, `word_count`=0. After release, no stale vector ever appears.
